// File: rtl/fft_stage_ctrl_if.sv
// Handshake and control bundle between an FFT stage controller and its datapath neighbours.
// No logic or latency: the bundle only carries signals.
// Backpressure travels on in_ready. The stage drops in_ready while it drains its delay line.
interface fft_stage_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic flush;
  logic dl_shift;
  logic bf_sel;
  logic tw_pop;
  logic out_valid;
  logic out_sof;
  logic out_eof;
  logic busy;
  logic err;

  // Upstream source and downstream observer side.
  modport master (
    output in_valid, flush,
    input  in_ready, dl_shift, bf_sel, tw_pop, out_valid, out_sof, out_eof, busy, err
  );

  // Controller side.
  modport slave (
    input  in_valid, flush,
    output in_ready, dl_shift, bf_sel, tw_pop, out_valid, out_sof, out_eof, busy, err
  );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Purpose: sequences one radix-2 SDF FFT stage: it fills and computes half-spans and drains the delay line on flush.
// Latency: outputs are combinational from the state and the current transfer, with no added cycles.
// Backpressure: in_ready is high except during FLUSH. Optional sticky error flag under `FFT_STAGE_CTRL_ERR_EN.
module fft_stage_ctrl #(
  parameter int SET   = 3,
  parameter int STAGE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  fft_stage_ctrl_if.slave bus
);

  localparam int N   = 2 ** SET;
  localparam int D   = 2 ** (SET - 1 - STAGE);
  localparam int HCW = (D > 1) ? $clog2(D) : 1;
  localparam logic [HCW-1:0] HC_LAST = HCW'(D - 1);
  localparam logic [HCW-1:0] HC_ONE  = (D > 1) ? HCW'(1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMPUTE, S_FLUSH} state_t;

  // A one-sample half-span means the first sample already completes the fill half.
  localparam state_t FIRST_HALF = (D > 1) ? S_FILL : S_COMPUTE;

  state_t           state_q, state_d;
  logic [HCW-1:0]   hc_q, hc_d;
  logic [SET-1:0]   fc_q, fc_d;
  logic [SET-1:0]   oc_q, oc_d;
  logic             primed_q, primed_d;

  logic in_ready;
  logic flush_acc;
  logic xfer;
  logic hc_wrap;
  logic diff_out;
  logic out_valid;

  // A flush is honoured only on a frame boundary with differences still pending.
  assign in_ready  = (state_q != S_FLUSH);
  assign flush_acc = bus.flush && (state_q == S_FILL) && (hc_q == '0) && primed_q;
  assign xfer      = bus.in_valid && in_ready && !flush_acc;
  assign hc_wrap   = (hc_q == HC_LAST);

  // Difference outputs (twiddled) come from the FILL of the next half or from the drain.
  assign diff_out  = ((state_q == S_FILL) && primed_q && xfer) || (state_q == S_FLUSH);
  assign out_valid = ((state_q == S_COMPUTE) && xfer) || diff_out;

  assign bus.in_ready  = in_ready;
  assign bus.dl_shift  = xfer || (state_q == S_FLUSH);
  assign bus.bf_sel    = (state_q == S_COMPUTE);
  assign bus.tw_pop    = diff_out;
  assign bus.out_valid = out_valid;
  assign bus.out_sof   = out_valid && (oc_q == '0);
  assign bus.out_eof   = out_valid && (oc_q == '1);
  assign bus.busy      = (state_q != S_IDLE);

  // Next-state logic for the stage sequencer and its counters.
  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    fc_d     = fc_q;
    primed_d = primed_q;
    oc_d     = out_valid ? oc_q + 1'b1 : oc_q;
    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          fc_d    = SET'(1);
          hc_d    = HC_ONE;
          state_d = FIRST_HALF;
        end
      end
      S_FILL: begin
        if (flush_acc) begin
          hc_d    = '0;
          state_d = S_FLUSH;
        end else if (xfer) begin
          fc_d = fc_q + 1'b1;
          if (hc_wrap) begin
            hc_d    = '0;
            state_d = S_COMPUTE;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (xfer) begin
          fc_d = fc_q + 1'b1;
          if (hc_wrap) begin
            hc_d     = '0;
            primed_d = 1'b1;
            state_d  = S_FILL;
          end else begin
            hc_d = hc_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        // hc counts drain cycles here; the stream restarts cleanly afterwards.
        if (hc_wrap) begin
          hc_d     = '0;
          fc_d     = '0;
          oc_d     = '0;
          primed_d = 1'b0;
          state_d  = S_IDLE;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hc_q     <= '0;
      fc_q     <= '0;
      oc_q     <= '0;
      primed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      fc_q     <= fc_d;
      oc_q     <= oc_d;
      primed_q <= primed_d;
    end
  end

`ifdef FFT_STAGE_CTRL_ERR_EN
  logic err_q, err_d;

  // Sticky flag for a flush off the frame boundary or for data offered while draining.
  always_comb begin
    err_d = err_q;
    if ((bus.flush && !flush_acc) || (bus.in_valid && (state_q == S_FLUSH))) err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl with SET=3 and STAGE=0 (N=8, D=4).
// The reference model works from transfer and output counts, not from controller state.
// Vector order: {in_ready, dl_shift, bf_sel, tw_pop, out_valid, out_sof, out_eof, busy, err}.
module tb_fft_stage_ctrl;

  localparam int SET = 3;
  localparam int STAGE = 0;
  localparam int N = 2 ** SET;
  localparam int D = 2 ** (SET - 1 - STAGE);
`ifdef FFT_STAGE_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [8:0] RST_VEC = 9'b1_0000_0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  // Reference model: transfers in the current stream, drain cycles left, outputs emitted, error flag.
  int m_k;
  int m_fr;
  int m_outs;
  bit m_err;

  fft_stage_ctrl_if bus ();

  fft_stage_ctrl #(.SET(SET), .STAGE(STAGE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  function automatic logic [8:0] observe();
    return {bus.in_ready, bus.dl_shift, bus.bf_sel, bus.tw_pop, bus.out_valid,
            bus.out_sof, bus.out_eof, bus.busy, bus.err};
  endfunction

  task automatic model_reset();
    m_k = 0; m_fr = 0; m_outs = 0; m_err = 1'b0;
  endtask

  // Runs one clock with the given inputs and returns the observed and predicted vectors.
  // The task is entered and left 1 time unit after a rising edge.
  task automatic drive(input bit v, input bit f, output logic [8:0] obs, output logic [8:0] exp);
    bit rdy, facc, xfer, ov, tw, bf;
    int p;
    bus.in_valid = v;
    bus.flush    = f;
    @(negedge clk);
    p    = m_k % (2 * D);
    rdy  = (m_fr == 0);
    facc = f && rdy && (m_k > 0) && (p == 0);
    xfer = v && rdy && !facc;
    bf   = rdy && (m_k > 0) && (p >= D);
    ov   = (m_fr > 0) || (xfer && ((p >= D) || (m_k >= 2 * D)));
    tw   = (m_fr > 0) || (xfer && (p < D) && (m_k >= 2 * D));
    exp  = {rdy, xfer || (m_fr > 0), bf, tw, ov,
            ov && (m_outs % N == 0), ov && (m_outs % N == N - 1),
            (m_k > 0) || (m_fr > 0), m_err};
    obs  = observe();
    @(posedge clk);
    #1;
    if (ERR_EN && ((f && !facc) || (v && m_fr > 0))) m_err = 1'b1;
    if (ov) m_outs++;
    if (m_fr > 0) begin
      m_fr--;
      if (m_fr == 0) begin m_k = 0; m_outs = 0; end
    end else if (facc) begin
      m_fr = D;
    end
    if (xfer) m_k++;
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [8:0] o;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rst_n = 1'b0;
    #1;
    o = observe();
    n_checks++;
    if (o !== RST_VEC) begin n_errors++; $display("FAIL reset_vec: got %b expected %b", o, RST_VEC); end
    @(posedge clk);
    #1;
    o = observe();
    n_checks++;
    if (o !== RST_VEC) begin n_errors++; $display("FAIL reset_hold: got %b expected %b", o, RST_VEC); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_fill_compute();
    logic [8:0] o, e;
    int nov = 0, ntw = 0, nbf = 0;
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL fill_compute cyc %0d: got %b expected %b", i, o, e); end
      nov += int'(o[4]); ntw += int'(o[5]); nbf += int'(o[6] & o[4]);
    end
    n_checks++;
    if (nov !== 4 || ntw !== 0 || nbf !== 4) begin
      n_errors++;
      $display("FAIL fill_compute_counts: got ov=%0d tw=%0d bf=%0d expected ov=4 tw=0 bf=4", nov, ntw, nbf);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] o, e;
    int nov = 0, ntw = 0, nsof = 0, neof = 0;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL back_to_back cyc %0d: got %b expected %b", i, o, e); end
      nov += int'(o[4]); ntw += int'(o[5]); nsof += int'(o[3]); neof += int'(o[2]);
    end
    n_checks++;
    if (nov !== 12 || ntw !== 4 || nsof !== 2 || neof !== 1) begin
      n_errors++;
      $display("FAIL back_to_back_counts: got ov=%0d tw=%0d sof=%0d eof=%0d expected 12 4 2 1",
               nov, ntw, nsof, neof);
    end
  endtask

  task automatic test_flush();
    logic [8:0] o, e;
    int nov = 0, ntw = 0, neof = 0;
    apply_reset();
    for (int i = 1; i <= 14; i++) begin
      // Samples 1..8, flush on cycle 9 with in_valid also high, drain on 10..13, then idle.
      drive(i <= 9, i == 9, o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL flush cyc %0d: got %b expected %b", i, o, e); end
      nov += int'(o[4]); ntw += int'(o[5]); neof += int'(o[2]);
    end
    n_checks++;
    if (nov !== 8 || ntw !== 4 || neof !== 1 || o[1] !== 1'b0 || o[8] !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_counts: got ov=%0d tw=%0d eof=%0d busy=%b rdy=%b expected 8 4 1 0 1",
               nov, ntw, neof, o[1], o[8]);
    end
  endtask

  task automatic test_gapped();
    logic [8:0] o, e;
    int nov = 0, ntw = 0, nsof = 0, neof = 0, i = 0;
    apply_reset();
    while (m_k < 16 && i < 100) begin
      drive(i % 3 == 0, 1'b0, o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL gapped cyc %0d: got %b expected %b", i, o, e); end
      nov += int'(o[4]); ntw += int'(o[5]); nsof += int'(o[3]); neof += int'(o[2]);
      i++;
    end
    n_checks++;
    if (m_k != 16 || nov !== 12 || ntw !== 4 || nsof !== 2 || neof !== 1) begin
      n_errors++;
      $display("FAIL gapped_counts: got xfer=%0d ov=%0d tw=%0d sof=%0d eof=%0d expected 16 12 4 2 1",
               m_k, nov, ntw, nsof, neof);
    end
  endtask

  task automatic test_ignored_flush();
    logic [8:0] o, e;
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      // Flush arrives after two samples (mid fill half) and must not start a drain.
      drive(i != 3, i == 3, o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL ignored_flush cyc %0d: got %b expected %b", i, o, e); end
    end
    n_checks++;
    if (bus.err !== ERR_EN || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ignored_flush_err: got err=%b rdy=%b expected err=%b rdy=1", bus.err, bus.in_ready, ERR_EN);
    end
  endtask

  task automatic test_random();
    logic [8:0] o, e;
    bit v, f;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (m_k > 0 && m_k % (2 * D) == 0) f = ($urandom_range(0, 1) == 1);
      else                              f = ($urandom_range(0, 15) == 0);
      drive(v, f, o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL random cyc %0d: got %b expected %b", i, o, e); end
    end
  endtask

  task automatic test_reset_flush();
    logic [8:0] o, e;
    int ntw = 0;
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      // Eight samples, flush accepted on cycle 9, first drain cycle on 10.
      drive(i <= 8, i == 9, o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset_flush pre cyc %0d: got %b expected %b", i, o, e); end
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    rst_n = 1'b0;
    #1;
    o = observe();
    n_checks++;
    if (o !== RST_VEC) begin n_errors++; $display("FAIL reset_flush_async: got %b expected %b", o, RST_VEC); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, o, e);
      n_checks++;
      if (o !== e) begin n_errors++; $display("FAIL reset_flush post cyc %0d: got %b expected %b", i, o, e); end
      ntw += int'(o[5]);
    end
    n_checks++;
    if (ntw !== 0) begin n_errors++; $display("FAIL reset_flush_tw: got %0d pops expected 0", ntw); end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    test_reset();
    test_fill_compute();
    test_back_to_back();
    test_flush();
    test_gapped();
    test_ignored_flush();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
